// File: rtl/event_timestamp_queue_if.sv
// Read-side bus of the event timestamp queue: pop request, popped entry and FIFO status.
// The master is the DSP control logic, the slave is the queue itself.
interface event_timestamp_queue_if #(
    parameter int CH_W  = 2,
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                 rd_en_i;
    logic [CH_W+TS_W-1:0] rd_data_o;
    logic                 rd_valid_o;
    logic                 empty_o;
    logic                 full_o;
    logic [LVL_W-1:0]     level_o;

    modport master (
        output rd_en_i,
        input  rd_data_o,
        input  rd_valid_o,
        input  empty_o,
        input  full_o,
        input  level_o
    );

    modport slave (
        input  rd_en_i,
        output rd_data_o,
        output rd_valid_o,
        output empty_o,
        output full_o,
        output level_o
    );
endinterface

// File: rtl/event_timestamp_queue.sv
// Round-robin capture of latched event flags into a {channel, timestamp} FIFO,
// with a one-cycle clear pulse back to the originating latch and a registered read port.
module event_timestamp_queue #(
    parameter int N_CH  = 4,
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_CH-1:0]        event_i,
    output logic [N_CH-1:0]        clr_o,
    input  logic                   enable_i,
    input  logic                   ts_clr_i,
    output logic                   overflow_o,
    input  logic                   ovf_clr_i,
    event_timestamp_queue_if.slave rd_bus
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = CH_W + TS_W;

    logic [ENT_W-1:0] mem_q [DEPTH];

    logic [TS_W-1:0]  ts_q,       ts_d;
    logic [CH_W-1:0]  rr_q,       rr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0] count_q,    count_d;
    logic             empty_q,    empty_d;
    logic             full_q,     full_d;
    logic [N_CH-1:0]  clr_q,      clr_d;
    logic             ovf_q,      ovf_d;
    logic [ENT_W-1:0] rd_data_q,  rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic [N_CH-1:0]  pend_s;
    logic [N_CH-1:0]  pend_rot_s;
    logic             win_found_s;
    logic [CH_W-1:0]  win_off_s;
    logic [CH_W:0]    win_sum_s;
    logic [CH_W-1:0]  win_s;
    logic             cap_s;
    logic             ovf_set_s;
    logic             rd_fire_s;

    // Round-robin pick: rotate so rr_q sits at bit 0, take the lowest set bit, map back.
    always_comb begin
        pend_s      = event_i & ~clr_q;
        pend_rot_s  = N_CH'({pend_s, pend_s} >> rr_q);
        win_found_s = 1'b0;
        win_off_s   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!win_found_s && pend_rot_s[i]) begin
                win_found_s = 1'b1;
                win_off_s   = CH_W'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
        win_sum_s = {1'b0, rr_q} + {1'b0, win_off_s};
        if (win_sum_s >= (CH_W+1)'(N_CH)) begin
            win_sum_s = win_sum_s - (CH_W+1)'(N_CH);
        end else begin
            win_sum_s = win_sum_s;
        end
        win_s = win_sum_s[CH_W-1:0];
    end

    // Next state: capture and read are both judged on the pre-edge count, so a
    // full FIFO blocks capture and an empty FIFO ignores a read even if the other side moves.
    always_comb begin
        cap_s     = enable_i & ~full_q & win_found_s;
        ovf_set_s = enable_i &  full_q & win_found_s;
        rd_fire_s = rd_bus.rd_en_i & ~empty_q;

        if (ts_clr_i) begin
            ts_d = '0;
        end else begin
            ts_d = ts_q + TS_W'(1'b1);
        end

        if (cap_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            clr_d    = N_CH'(1'b1) << win_s;
            if (win_s == CH_W'(N_CH - 1)) begin
                rr_d = '0;
            end else begin
                rr_d = win_s + CH_W'(1'b1);
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
            clr_d    = '0;
            rr_d     = rr_q;
        end

        if (rd_fire_s) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1'b1);
            rd_data_d = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d  = rd_ptr_q;
            rd_data_d = rd_data_q;
        end
        rd_valid_d = rd_fire_s;

        case ({cap_s, rd_fire_s})
            2'b10:   count_d = count_q + LVL_W'(1'b1);
            2'b01:   count_d = count_q - LVL_W'(1'b1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == LVL_W'(1'b0));
        full_d  = (count_d == LVL_W'(DEPTH));

        // Set dominates clear so a stall in the clearing cycle is never lost.
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ts_q       <= '0;
            rr_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            clr_q      <= '0;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            rr_q       <= rr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            clr_q      <= clr_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (rst_ni && cap_s) begin
            mem_q[wr_ptr_q] <= {win_s, ts_q};
        end
    end

    assign clr_o             = clr_q;
    assign overflow_o        = ovf_q;
    assign rd_bus.rd_data_o  = rd_data_q;
    assign rd_bus.rd_valid_o = rd_valid_q;
    assign rd_bus.empty_o    = empty_q;
    assign rd_bus.full_o     = full_q;
    assign rd_bus.level_o    = count_q;
endmodule

// File: tb/tb_event_timestamp_queue.sv
// Directed bench for event_timestamp_queue: expected entries go into a scoreboard
// queue at stimulus time and a negedge monitor compares every rd_valid_o pulse.
module tb_event_timestamp_queue;
    localparam int N_CH  = 4;
    localparam int TS_W  = 16;
    localparam int DEPTH = 8;
    localparam int CH_W  = 2;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [N_CH-1:0] event_i;
    logic [N_CH-1:0] clr_o;
    logic            enable_i;
    logic            ts_clr_i;
    logic            overflow_o;
    logic            ovf_clr_i;

    event_timestamp_queue_if #(.CH_W(CH_W), .TS_W(TS_W), .DEPTH(DEPTH)) bus ();

    event_timestamp_queue #(.N_CH(N_CH), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .event_i    (event_i),
        .clr_o      (clr_o),
        .enable_i   (enable_i),
        .ts_clr_i   (ts_clr_i),
        .overflow_o (overflow_o),
        .ovf_clr_i  (ovf_clr_i),
        .rd_bus     (bus)
    );

    always #5 clk = ~clk;

    int                       checks = 0;
    int                       errors = 0;
    logic [CH_W+TS_W-1:0]     exp_q [$];
    logic [TS_W-1:0]          exp_ts = '0;
    bit                       latch_on = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [CH_W-1:0] ch, input logic [TS_W-1:0] ts);
        exp_q.push_back({ch, ts});
    endtask

    // One clock: tracks the expected timestamp and emulates the upstream latch,
    // which drops a flag at the edge that ends its clear pulse.
    task automatic tick();
        logic [N_CH-1:0] c;
        logic            tc;
        logic            r;
        c  = clr_o;
        tc = ts_clr_i;
        r  = rst_ni;
        @(posedge clk);
        #1;
        if (!r || tc) exp_ts = '0;
        else          exp_ts = exp_ts + 16'd1;
        if (latch_on) event_i = event_i & ~c;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic pop_n(input int n);
        bus.rd_en_i = 1'b1;
        repeat (n) tick();
        bus.rd_en_i = 1'b0;
        tick();
    endtask

    // Monitor: every valid read must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.rd_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual=%0h expected=none", bus.rd_data_o);
            end else begin
                chk("rd_data", 32'(bus.rd_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [TS_W-1:0] t0;
        rst_ni      = 1'b0;
        event_i     = 4'b0000;
        enable_i    = 1'b1;
        ts_clr_i    = 1'b0;
        ovf_clr_i   = 1'b0;
        bus.rd_en_i = 1'b0;
        do_reset();

        chk("rst_empty",    32'(bus.empty_o),    32'd1);
        chk("rst_full",     32'(bus.full_o),     32'd0);
        chk("rst_level",    32'(bus.level_o),    32'd0);
        chk("rst_clr",      32'(clr_o),          32'd0);
        chk("rst_ovf",      32'(overflow_o),     32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        chk("rst_rd_data",  32'(bus.rd_data_o),  32'd0);

        // Single event at ts=5.
        repeat (5) tick();
        event_i = 4'b0001;
        push(2'd0, 16'd5);
        tick();
        chk("t1_clr_pulse", 32'(clr_o), 32'h1);
        chk("t1_level",     32'(bus.level_o), 32'd1);
        tick();
        chk("t1_clr_drop",  32'(clr_o), 32'h0);
        tick();
        chk("t1_no_dup",    32'(bus.level_o), 32'd1);

        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
        chk("t2_valid", 32'(bus.rd_valid_o), 32'd1);
        tick();
        chk("t2_valid_drop", 32'(bus.rd_valid_o), 32'd0);
        chk("t2_empty",      32'(bus.empty_o),    32'd1);

        // All four channels at once from rr_ptr=0.
        do_reset();
        repeat (3) tick();
        t0 = exp_ts;
        event_i = 4'b1111;
        for (int i = 0; i < 4; i++) push(CH_W'(i), t0 + 16'(i));
        repeat (6) tick();
        chk("t2_level4", 32'(bus.level_o), 32'd4);
        chk("t2_clr_idle", 32'(clr_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.rd_en_i = 1'b1;
            tick();
            bus.rd_en_i = 1'b0;
            chk("t2_pop_valid", 32'(bus.rd_valid_o), 32'd1);
            tick();
            chk("t2_pop_gap", 32'(bus.rd_valid_o), 32'd0);
        end
        chk("t2_empty_end", 32'(bus.empty_o), 32'd1);
        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
        chk("empty_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        chk("empty_rd_hold",  32'(bus.rd_data_o),  32'({2'd3, t0 + 16'd3}));
        chk("empty_rd_level", 32'(bus.level_o),    32'd0);

        // Fill to full with flags held high, then stall on channel 2.
        latch_on = 1'b0;
        t0 = exp_ts;
        event_i = 4'b1111;
        for (int i = 0; i < 8; i++) push(CH_W'(i % 4), t0 + 16'(i));
        repeat (8) tick();
        chk("t3_level8", 32'(bus.level_o), 32'd8);
        chk("t3_full",   32'(bus.full_o),  32'd1);
        event_i = 4'b0100;
        tick();
        chk("t3_ovf_set",   32'(overflow_o), 32'd1);
        chk("t3_clr_stall", 32'(clr_o),      32'h0);
        tick();
        chk("t3_level_hold", 32'(bus.level_o), 32'd8);
        chk("t3_clr_stall2", 32'(clr_o),       32'h0);
        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
        chk("t3_level7",  32'(bus.level_o), 32'd7);
        chk("t3_notfull", 32'(bus.full_o),  32'd0);
        push(2'd2, exp_ts);
        tick();
        chk("t3_resume_clr", 32'(clr_o),       32'h4);
        chk("t3_refull",     32'(bus.full_o),  32'd1);
        event_i  = 4'b0000;
        latch_on = 1'b1;
        tick();
        chk("t3_ovf_sticky", 32'(overflow_o), 32'd1);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("t3_ovf_clr", 32'(overflow_o), 32'd0);
        pop_n(8);
        chk("t3_drained", 32'(bus.empty_o), 32'd1);

        // Simultaneous capture and read at level 3 (rr_ptr=3 here).
        t0 = exp_ts;
        event_i = 4'b0111;
        for (int i = 0; i < 3; i++) push(CH_W'(i), t0 + 16'(i));
        repeat (5) tick();
        chk("t4_level3", 32'(bus.level_o), 32'd3);
        event_i     = 4'b1000;
        bus.rd_en_i = 1'b1;
        push(2'd3, exp_ts);
        tick();
        bus.rd_en_i = 1'b0;
        chk("t4_level_same", 32'(bus.level_o), 32'd3);
        repeat (3) tick();
        chk("t4_level_after", 32'(bus.level_o), 32'd3);
        pop_n(3);
        chk("t4_drained", 32'(bus.empty_o), 32'd1);

        // enable_i=0 leaves the flag pending.
        enable_i = 1'b0;
        event_i  = 4'b0010;
        repeat (3) tick();
        chk("en0_clr",   32'(clr_o),         32'h0);
        chk("en0_level", 32'(bus.level_o),   32'd0);
        enable_i = 1'b1;
        push(2'd1, exp_ts);
        tick();
        chk("en1_clr", 32'(clr_o), 32'h2);
        pop_n(1);

        // Timestamp clear at 0x1234, next capture stamps 0.
        while (exp_ts != 16'h1234) tick();
        ts_clr_i = 1'b1;
        tick();
        ts_clr_i = 1'b0;
        event_i  = 4'b0001;
        push(2'd0, 16'h0000);
        tick();
        chk("t5_clr", 32'(clr_o), 32'h1);
        pop_n(1);

        // Wrap 0xFFFF -> 0x0000 across two back-to-back captures (rr_ptr=1).
        while (exp_ts != 16'hFFFF) tick();
        event_i = 4'b0011;
        push(2'd1, 16'hFFFF);
        push(2'd0, 16'h0000);
        repeat (4) tick();
        chk("t5_wrap_level", 32'(bus.level_o), 32'd2);
        pop_n(2);

        // Reset while a clear pulse is outstanding and a read is requested.
        event_i = 4'b0100;
        tick();
        chk("t6_pre_clr", 32'(clr_o), 32'h4);
        rst_ni      = 1'b0;
        bus.rd_en_i = 1'b1;
        exp_q.delete();
        tick();
        rst_ni      = 1'b1;
        bus.rd_en_i = 1'b0;
        chk("t6_empty",    32'(bus.empty_o),    32'd1);
        chk("t6_clr",      32'(clr_o),          32'h0);
        chk("t6_ovf",      32'(overflow_o),     32'd0);
        chk("t6_level",    32'(bus.level_o),    32'd0);
        chk("t6_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        event_i = 4'b0010;
        push(2'd1, 16'h0000);
        tick();
        chk("t6_cap_clr", 32'(clr_o), 32'h2);
        pop_n(1);
        tick();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/event_timestamp_queue.md
Name: event_timestamp_queue

Overview:
- Downstream consumer of the per-channel synchronized event flags produced by the input-synchronizer/latch stage.
- Each cycle it picks at most one pending flag by round-robin and stores {channel, timestamp} in an internal FIFO.
- It returns a one-cycle clear pulse to the originating latch, closing the set/clear handshake.
- The FIFO is drained by the DSP control logic through a registered read port.

Parameters:
- N_CH, 4, number of event channels (1..16).
- TS_W, 16, free-running timestamp width.
- DEPTH, 8, FIFO entries; must be a power of two, >= 2.
- CH_W, derived local = max(1, clog2(N_CH)), channel-id width.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- event_i  in  N_CH  level flags from the sync/latch stage (1 = event pending).
- clr_o  out  N_CH  one-cycle clear pulse per channel, wired to the latch clear input.
- enable_i  in  1  1 = captures allowed; 0 = no captures, flags left pending.
- ts_clr_i  in  1  synchronous timestamp counter clear.
- rd_en_i  in  1  pop request.
- rd_data_o  out  CH_W+TS_W  popped entry, {channel, timestamp}.
- rd_valid_o  out  1  rd_data_o valid (one-cycle pulse).
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- level_o  out  clog2(DEPTH)+1  current entry count.
- overflow_o  out  1  sticky: a pending event was stalled by a full FIFO.
- ovf_clr_i  in  1  clears overflow_o.

Behaviour:
- Reset (rst_ni=0 at an edge): FIFO pointers and count = 0, ts = 0, round-robin pointer = 0. All outputs are 0 except empty_o = 1. Reset overrides every other input, including mid-capture and mid-read.
- Timestamp: ts increments by 1 every cycle and wraps 2^TS_W-1 -> 0. If ts_clr_i=1, ts becomes 0 next cycle, with priority over increment. The captured value is ts in the cycle the channel is selected.
- Eligible channels: pend[k] = event_i[k] & ~clr_o[k]. Masking with clr_o covers the cycle before the latch flag drops, so each event is captured exactly once.
- Selection: a capture occurs in a cycle when enable_i=1, count<DEPTH and any pend bit is set.
  - Winner is the first pend bit at or above rr_ptr, wrapping modulo N_CH.
  - After a capture, rr_ptr = winner+1 mod N_CH; otherwise rr_ptr is unchanged.
- Capture at edge t:
  - Entry {winner, ts} is written at wr_ptr; wr_ptr++ (wraps at DEPTH).
  - clr_o[winner]=1 during cycle t+1 only, and at most one clr_o bit is high at a time.
- Full: count==DEPTH blocks capture even if a read occurs in the same cycle; space freed by a read is usable next cycle. Stalled flags stay pending in the latch, so none are lost at this stage.
- Overflow: overflow_o sets at the edge where a capture is blocked only by full (enable_i=1, any pend). ovf_clr_i clears it; if set and clear happen in the same cycle, set wins.
- Read: if rd_en_i=1 and count>0 at edge t, rd_data_o gets the entry at rd_ptr, rd_valid_o=1 in cycle t+1, and rd_ptr++.
  - rd_en_i while empty is ignored: rd_valid_o=0 and rd_data_o holds its last value.
  - Read latency is 1 cycle.
- Simultaneous capture and read with 0<count<DEPTH: count is unchanged and both pointers advance.
- Capture into an empty FIFO with rd_en_i in the same cycle: the read is ignored, because empty is evaluated before the write.
- Status: empty_o, full_o and level_o are registered and reflect count after the edge.
- enable_i=0: no captures, no clr_o, no overflow set. Reads and the timestamp continue normally.

Test Plan:
- Reset, then event_i=4'b0001 held at ts=5 -> one entry {0,5}; clr_o=4'b0001 for exactly one cycle; level_o=1; no duplicate entry.
- Two-phase read check: pop the entry from the first test and confirm {0,5}. Then assert event_i=4'b1111 simultaneously at ts=T with rr_ptr=0 -> entries {0,T},{1,T+1},{2,T+2},{3,T+3} in that order. Pop all four -> rd_valid_o pulses one cycle after each rd_en_i, empty_o=1 after the last.
- Fill 8 entries with no reads, keep event_i[2]=1 -> full_o=1, overflow_o=1, clr_o stays 0. One pop -> capture resumes the following cycle. ovf_clr_i -> overflow_o=0.
- At level 3, a capture and a read on the same edge -> level_o stays 3 and the data order is preserved.
- ts_clr_i pulse at ts=0x1234 -> the next capture timestamp counts from 0. Run to 0xFFFF -> wraps to 0x0000.
- rst_ni=0 while an entry is being captured and clr_o is pending -> after reset: empty_o=1, clr_o=0, overflow_o=0, ts=0.
